serial_addsub_ctrl: RTL and testbench

Multi-cycle add/subtract sequencer that drives a single 4-bit adder/subtractor slice across wide operands. It processes one nibble per clock, LSB first, and chains the slice carry between nibbles. A start/busy/done handshake frames each operation. The block sits between a requesting datapath and the shared nibble adder, so a wide add or subtract costs one slice plus control instead of a full-width adder.

---
 rtl/serial_addsub_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit slice per clock, LSB first,
// with the slice carry chained between nibbles and a start/busy/done handshake.
module serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 m,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] s,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic [W-5:0]   acc;
    logic           mode;
    logic           c;
    logic [IW-1:0]  idx;

    logic           accept;
    logic           last;
    logic [5:0]     slice;
    logic [3:0]     sum4;
    logic           c_next;
    logic           c_msb;
    logic [W-1:0]   shifted;

    // Returns {carry into bit 3, carry out, 4-bit sum}; the carry into bit 3
    // is what the final nibble needs for two's-complement overflow.
    function automatic logic [5:0] nibble_addsub(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       sub,
        input logic       cin
    );
        logic [3:0] yx;
        logic [3:0] lo;
        logic [4:0] full;
        yx   = y ^ {4{sub}};
        lo   = {1'b0, x[2:0]} + {1'b0, yx[2:0]} + {3'b000, cin};
        full = {1'b0, x} + {1'b0, yx} + {4'b0000, cin};
        return {lo[3], full};
    endfunction

    assign accept  = start && (state != RUN);
    assign last    = (idx == IW'(NIBBLES - 1));
    assign slice   = nibble_addsub(opa[3:0], opb[3:0], mode, c);
    assign sum4    = slice[3:0];
    assign c_next  = slice[4];
    assign c_msb   = slice[5];
    // New nibble enters from the top so the oldest nibble ends up lowest.
    assign shifted = {sum4, acc};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = accept ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa  <= '0;
            opb  <= '0;
            acc  <= '0;
            mode <= 1'b0;
            c    <= 1'b0;
            idx  <= '0;
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            opa  <= a;
            opb  <= b;
            mode <= m;
            c    <= m;
            idx  <= '0;
        end else if (state == RUN) begin
            opa <= opa >> 4;
            opb <= opb >> 4;
            acc <= shifted[W-1:4];
            c   <= c_next;
            idx <= idx + 1'b1;
            // Only the final nibble publishes, so s never shows partial sums.
            if (last) begin
                s    <= shifted;
                cout <= c_next;
                ovf  <= c_msb ^ c_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized and directed bench for serial_addsub_ctrl against an arithmetic
// reference model (signed/unsigned integer math, not slice-level).
module tb_serial_addsub_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    serial_addsub_ctrl #(.NIBBLES(NIB)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .m    (m),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .s    (s),
        .cout (cout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // {ovf, cout, s} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
        longint ux, uy, us, sx, sy, st;
        logic   rc, ro;
        logic [W-1:0] rs;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sub) begin
            us = ux - uy;
            st = sx - sy;
            rc = (ux >= uy);
        end else begin
            us = ux + uy;
            st = sx + sy;
            rc = (us >= (longint'(1) << W));
        end
        rs = W'(us);
        ro = (st > ((longint'(1) << (W - 1)) - 1)) || (st < -(longint'(1) << (W - 1)));
        return {ro, rc, rs};
    endfunction

    // Called #1 after an edge; launches an op and follows it to done.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic mi,
                         input bit noise, input bit chk_fall,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        int  n;
        bit  got;
        got   = 0;
        start = 1'b1;
        a     = ai;
        b     = bi;
        m     = mi;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        for (n = 1; n <= NIB + 4; n++) begin
            if (noise) begin
                start = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                m     = 1'($urandom);
            end
            @(posedge clk);
            #1;
            if (done) begin
                got = 1;
                break;
            end
        end
        start = 1'b0;
        check("latency", 32'(n), 32'(NIB));
        check("done_seen", 32'(got), 32'd1);
        check("s", 32'(s), 32'(es));
        check("cout", 32'(cout), 32'(ec));
        check("ovf", 32'(ovf), 32'(eo));
        check("busy_at_done", 32'(busy), 32'd0);
        if (chk_fall) begin
            @(posedge clk);
            #1;
            check("done_fall", 32'(done), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    task automatic rand_op(input bit noise);
        logic [W-1:0] ai, bi;
        logic         mi;
        logic [W+1:0] r;
        ai = W'($urandom);
        bi = W'($urandom);
        mi = 1'($urandom);
        r  = ref_op(ai, bi, mi);
        do_op(ai, bi, mi, noise, 1'b1, r[W-1:0], r[W], r[W+1]);
    endtask

    initial begin
        logic [W-1:0] hs;
        logic         hc, ho;
        logic [W+1:0] r1, r2;

        rst   = 1'b1;
        start = 1'b0;
        m     = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed add / subtract cases
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Starts while busy are ignored
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b1, 1'b1, 16'h2233, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-to-back: second start presented during the DONE cycle
        r1 = ref_op(16'hA5A5, 16'h1111, 1'b0);
        r2 = ref_op(16'h0100, 16'h0200, 1'b1);
        do_op(16'hA5A5, 16'h1111, 1'b0, 1'b0, 1'b0, r1[W-1:0], r1[W], r1[W+1]);
        do_op(16'h0100, 16'h0200, 1'b1, 1'b0, 1'b1, r2[W-1:0], r2[W], r2[W+1]);

        // Hold: outputs stay put while inputs wiggle without start
        hs = s;
        hc = cout;
        ho = ovf;
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            m = 1'($urandom);
            @(posedge clk);
            #1;
            check("hold_s", 32'(s), 32'(hs));
            check("hold_cout", 32'(cout), 32'(hc));
            check("hold_ovf", 32'(ovf), 32'(ho));
            check("hold_busy", 32'(busy), 32'd0);
        end

        // Reset during RUN aborts with no done pulse
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        m     = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_s", 32'(s), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NIB + 2; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end

        // Random operations with random idle gaps
        for (int i = 0; i < 1000; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                a = W'($urandom);
                b = W'($urandom);
                m = 1'($urandom);
                @(posedge clk);
                #1;
            end
            rand_op(($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
